// File: rtl/imm_byte_sequencer_if.sv
//----------------------------------------------------------------------------
// Module   : imm_byte_sequencer_if
// Brief    : Byte-stream input and assembled-word output bundle of the
//            immediate byte sequencer.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface imm_byte_sequencer_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic [1:0]       mode;
  logic             flush;
  logic [15:0]      word_out;
  logic             word_valid;
  logic             word_ready;
  logic             busy;
  logic             timeout_err;
  logic [CNT_W-1:0] words_done;

  // Fetch / register-write side.
  modport master (
    output byte_in, byte_valid, mode, flush, word_ready,
    input  byte_ready, word_out, word_valid, busy, timeout_err, words_done
  );

  // Sequencer side.
  modport slave (
    input  byte_in, byte_valid, mode, flush, word_ready,
    output byte_ready, word_out, word_valid, busy, timeout_err, words_done
  );
endinterface

`default_nettype wire

// File: rtl/imm_byte_sequencer.sv
//----------------------------------------------------------------------------
// Module   : imm_byte_sequencer
// Brief    : Assembles one 16-bit immediate per instruction from an 8-bit
//            byte stream and hands it to register write over valid/ready.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module imm_byte_sequencer #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  imm_byte_sequencer_if.slave bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] c_TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  localparam logic [1:0] c_MODE_FULL  = 2'b00;
  localparam logic [1:0] c_MODE_UPPER = 2'b01;
  localparam logic [1:0] c_MODE_SEXT  = 2'b10;
  localparam logic [1:0] c_MODE_ZEXT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_LO = 2'd1,
    S_OUT     = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_mode;
  logic [15:0]      r_word;
  logic             r_word_valid;
  logic             r_busy;
  logic             r_terr;
  logic [CNT_W-1:0] r_done;
  logic [TW-1:0]    r_tcnt;

  logic             w_byte_ready;
  logic             w_byte_xfer;
  logic [15:0]      w_first_word;
  logic [7:0]       w_lo_merge;

  assign w_byte_ready = (r_state != S_OUT) && !bus.flush;
  assign w_byte_xfer  = w_byte_ready && bus.byte_valid;

  // Word image produced by the first byte of any mode; FULL parks b0 high.
  always_comb begin
    w_first_word = {bus.byte_in, 8'h00};
    case (bus.mode)
      c_MODE_FULL:  w_first_word = {bus.byte_in, 8'h00};
      c_MODE_UPPER: w_first_word = {bus.byte_in, 8'h00};
      c_MODE_SEXT:  w_first_word = {{8{bus.byte_in[7]}}, bus.byte_in};
      c_MODE_ZEXT:  w_first_word = {8'h00, bus.byte_in};
      default:      w_first_word = {bus.byte_in, 8'h00};
    endcase
  end

  // The partial low byte is always zero in WAIT_LO, so the OR is a plain merge.
  assign w_lo_merge = (r_mode == c_MODE_FULL) ? (r_word[7:0] | bus.byte_in) : r_word[7:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_mode       <= c_MODE_FULL;
      r_word       <= 16'h0000;
      r_word_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_terr       <= 1'b0;
      r_done       <= '0;
      r_tcnt       <= '0;
    end else begin
      r_terr <= 1'b0;
      if (bus.flush) begin
        r_state      <= S_IDLE;
        r_word_valid <= 1'b0;
        r_busy       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_byte_xfer) begin
              r_mode <= bus.mode;
              r_word <= w_first_word;
              r_busy <= 1'b1;
              if (bus.mode == c_MODE_FULL) begin
                r_tcnt  <= '0;
                r_state <= S_WAIT_LO;
              end else begin
                r_word_valid <= 1'b1;
                r_state      <= S_OUT;
              end
            end
          end
          S_WAIT_LO: begin
            if (w_byte_xfer) begin
              r_word[7:0]  <= w_lo_merge;
              r_word_valid <= 1'b1;
              r_state      <= S_OUT;
            end else if ((TIMEOUT != 0) && (r_tcnt == c_TLAST)) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_terr  <= 1'b1;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          S_OUT: begin
            if (bus.word_ready) begin
              r_word_valid <= 1'b0;
              r_busy       <= 1'b0;
              r_done       <= r_done + 1'b1;
              r_state      <= S_IDLE;
            end
          end
          default: begin
            r_state      <= S_IDLE;
            r_word_valid <= 1'b0;
            r_busy       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.byte_ready  = w_byte_ready;
  assign bus.word_out    = r_word;
  assign bus.word_valid  = r_word_valid;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_terr;
  assign bus.words_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_imm_byte_sequencer.sv
//----------------------------------------------------------------------------
// Module   : tb_imm_byte_sequencer
// Brief    : Directed and randomized bench for imm_byte_sequencer against a
//            transaction-level reference model.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_imm_byte_sequencer;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  imm_byte_sequencer_if #(.CNT_W(CNT_W)) bus ();

  imm_byte_sequencer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: "holding a high byte", "word waiting for consumer".
  logic             m_have_hi;
  logic [7:0]       m_hi;
  int               m_waited;
  logic             m_out;
  logic [15:0]      m_word;
  logic [CNT_W-1:0] m_done;
  logic             m_terr;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have_hi = 1'b0;
    m_hi      = 8'h00;
    m_waited  = 0;
    m_out     = 1'b0;
    m_word    = 16'h0000;
    m_done    = '0;
    m_terr    = 1'b0;
  endtask

  task automatic model_edge(input logic rdy);
    logic take;
    if (!reset_n) begin
      model_reset();
      return;
    end
    take   = bus.byte_valid && rdy;
    m_terr = 1'b0;
    if (bus.flush) begin
      m_have_hi = 1'b0;
      m_out     = 1'b0;
    end else if (m_out) begin
      if (bus.word_ready) begin
        m_out  = 1'b0;
        m_done = m_done + 1'b1;
      end
    end else if (m_have_hi) begin
      if (take) begin
        m_word    = m_hi * 256 + bus.byte_in;
        m_have_hi = 1'b0;
        m_out     = 1'b1;
      end else begin
        m_waited++;
        if (TIMEOUT != 0 && m_waited == TIMEOUT) begin
          m_have_hi = 1'b0;
          m_terr    = 1'b1;
        end
      end
    end else if (take) begin
      case (bus.mode)
        2'd0: begin m_have_hi = 1'b1; m_hi = bus.byte_in; m_waited = 0; end
        2'd1: begin m_word = bus.byte_in * 256;            m_out = 1'b1; end
        2'd2: begin m_word = 16'($signed(bus.byte_in));    m_out = 1'b1; end
        default: begin m_word = 16'(bus.byte_in);          m_out = 1'b1; end
      endcase
    end
  endtask

  task automatic step();
    logic exp_rdy;
    @(negedge clk);
    exp_rdy = !bus.flush && !m_out;
    check_val("byte_ready", bus.byte_ready, exp_rdy);
    @(posedge clk);
    model_edge(exp_rdy);
    #1;
    check_val("word_valid", bus.word_valid, m_out);
    check_val("busy", bus.busy, m_have_hi || m_out);
    check_val("timeout_err", bus.timeout_err, m_terr);
    check_val("words_done", bus.words_done, m_done);
    if (m_out) check_val("word_out", bus.word_out, m_word);
  endtask

  task automatic drive(input logic bv, input logic [1:0] md, input logic [7:0] b,
                       input logic wr, input logic fl);
    bus.byte_valid = bv;
    bus.mode       = md;
    bus.byte_in    = b;
    bus.word_ready = wr;
    bus.flush      = fl;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int pbv;
    int pwr;
    logic [CNT_W-1:0] done_snap;

    reset_n = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    check_val("rst_word_out", bus.word_out, 16'h0000);
    check_val("rst_word_valid", bus.word_valid, 1'b0);
    check_val("rst_busy", bus.busy, 1'b0);
    check_val("rst_timeout_err", bus.timeout_err, 1'b0);
    check_val("rst_words_done", bus.words_done, 0);
    reset_n = 1'b1;

    // FULL 0x12,0x34 back to back.
    drive(1'b1, 2'd0, 8'h12, 1'b1, 1'b0); step();
    drive(1'b1, 2'd0, 8'h34, 1'b1, 1'b0); step();
    check_val("full_word", bus.word_out, 16'h1234);
    check_val("full_rdy_in_out", bus.byte_ready, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0); step();
    check_val("full_done", bus.words_done, 1);

    // Single-byte modes.
    drive(1'b1, 2'd1, 8'hAB, 1'b1, 1'b0); step();
    check_val("upper_word", bus.word_out, 16'hAB00);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0); step();
    drive(1'b1, 2'd2, 8'h80, 1'b1, 1'b0); step();
    check_val("sext_word", bus.word_out, 16'hFF80);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0); step();
    drive(1'b1, 2'd3, 8'h80, 1'b1, 1'b0); step();
    check_val("zext_word", bus.word_out, 16'h0080);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0); step();

    // Back-pressure: word held, offered bytes not consumed.
    drive(1'b1, 2'd0, 8'hDE, 1'b0, 1'b0); step();
    drive(1'b1, 2'd0, 8'hAD, 1'b0, 1'b0); step();
    done_snap = bus.words_done;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd1, 8'h99, 1'b0, 1'b0); step();
      check_val("hold_word", bus.word_out, 16'hDEAD);
    end
    check_val("hold_done", bus.words_done, done_snap);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0); step();
    check_val("hold_release", bus.words_done, done_snap + 1'b1);

    // Timeout after a lone high byte.
    drive(1'b1, 2'd0, 8'h55, 1'b1, 1'b0); step();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0); step();
      if (bus.timeout_err) pulses++;
    end
    check_val("timeout_pulses", pulses, 1);
    drive(1'b1, 2'd1, 8'h77, 1'b1, 1'b0); step();
    check_val("after_timeout_word", bus.word_out, 16'h7700);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0); step();

    // Flush in WAIT_LO, then in OUT with word_ready high.
    done_snap = bus.words_done;
    drive(1'b1, 2'd0, 8'h11, 1'b1, 1'b0); step();
    drive(1'b1, 2'd0, 8'h22, 1'b1, 1'b1); step();
    check_val("flush_wait_busy", bus.busy, 1'b0);
    drive(1'b1, 2'd3, 8'h33, 1'b1, 1'b0); step();
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b1); step();
    check_val("flush_out_valid", bus.word_valid, 1'b0);
    check_val("flush_out_done", bus.words_done, done_snap);

    // Reset while in OUT.
    drive(1'b1, 2'd2, 8'h80, 1'b0, 1'b0); step();
    reset_n = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0); step();
    check_val("rst_out_word", bus.word_out, 16'h0000);
    check_val("rst_out_done", bus.words_done, 0);
    reset_n = 1'b1;

    // 256 back-to-back single-byte words wrap the counter.
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, 2'd3, 8'(i), 1'b1, 1'b0); step();
    end
    check_val("wrap_done", bus.words_done, 0);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0); step();

    // Randomized traffic with varying density, back-pressure, flush, reset.
    for (int seg = 0; seg < 60; seg++) begin
      case ($urandom_range(0, 2))
        0: pbv = 4;
        1: pbv = 50;
        default: pbv = 95;
      endcase
      pwr = ($urandom_range(0, 1) == 0) ? 30 : 90;
      for (int c = 0; c < 50; c++) begin
        reset_n = ($urandom_range(0, 299) != 0);
        drive(($urandom_range(0, 99) < pbv), 2'($urandom), 8'($urandom),
              ($urandom_range(0, 99) < pwr), ($urandom_range(0, 39) == 0));
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
